// File: rtl/meter_tx_pkg.sv
// meter_tx_pkg: shared definitions for the meter frame transmitter.
//   tx_state_t   - per-byte serializer states (IDLE, START, DATA, STOP)
//   HEADER_BYTE  - first byte of every frame
//   FRAME_LEN_*  - frame length with and without the trailing checksum
//   FRAME_LEN    - active frame length, selected by METER_FRAME_CHECKSUM_EN
//   frame_checksum() - mod-256 sum of status + 12 data bytes (checksum build only)
package meter_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [7:0]  HEADER_BYTE     = 8'hA5;
  localparam int unsigned FRAME_LEN_PLAIN = 14;
  localparam int unsigned FRAME_LEN_CSUM  = 15;

`ifdef METER_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CSUM;

  function automatic logic [7:0] frame_checksum(input logic [7:0]  status,
                                                input logic [95:0] words);
    logic [7:0]  sum;
    logic [95:0] rest;
    sum  = status;
    rest = words;
    for (int unsigned i = 0; i < 12; i++) begin
      sum  = sum + rest[7:0];
      rest = rest >> 8;
    end
    return sum;
  endfunction
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_PLAIN;
`endif

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serializes one byte as start(0), 8 data bits LSB first, stop(1),
// each bit held CLKS_PER_BIT clocks.
//   clk, reset (async, active-low)
//   load      - accept byte_in; honoured in IDLE, and on the last stop-bit cycle
//               so consecutive bytes go out with no idle bit between them
//   byte_in   - byte to send
//   txd       - registered serial output, idle high
//   byte_done - high on the final clock of the stop bit
module uart_byte_tx
  import meter_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       txd,
  output logic       byte_done
);

  localparam int unsigned     BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  assign byte_done = (state == STOP) && (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg    <= byte_in;
            baud_cnt <= '0;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            // bit_cnt wraps 7 -> 0 on its own as the byte finishes
            bit_cnt  <= bit_cnt + 3'd1;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (load) begin
              shreg <= byte_in;
              txd   <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/meter_frame_tx.sv
// meter_frame_tx: captures three measurement words plus mode/range flags on an
// accepted start and sends them as a UART frame:
//   A5, {5'b0, high_Frequency, mode}, first/second/third_data MSB byte first,
//   then a mod-256 checksum byte when METER_FRAME_CHECKSUM_EN is defined.
// Ports:
//   clk, reset (async, active-low)
//   start                    - frame request, ignored while busy
//   first/second/third_data  - 32-bit words, latched on the accepting edge
//   mode[1:0], high_Frequency - packed into the status byte
//   txd  - serial line, idle high
//   busy - high while a frame is in flight
//   done - one-cycle pulse as the last stop bit completes (busy drops with it)
module meter_frame_tx
  import meter_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] first_data,
  input  logic [31:0] second_data,
  input  logic [31:0] third_data,
  input  logic [1:0]  mode,
  input  logic        high_Frequency,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned   IW           = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] IDX_LAST     = IW'(FRAME_LEN - 1);

  logic [7:0]    status_q;
  logic [95:0]   words_q;
  logic [IW-1:0] byte_idx;
  logic [IW-1:0] load_idx;
  logic [7:0]    byte_in;
  logic [95:0]   word_sh;
  logic          accept;
  logic          more;
  logic          load;
  logic          byte_done;

  assign accept   = start && !busy;
  assign more     = (byte_idx != IDX_LAST);
  assign load     = accept || (byte_done && more);
  // Header goes out on the accepting edge itself, so its byte is constant and
  // needs no latched data; later bytes are picked from the latched copy.
  assign load_idx = accept ? '0 : byte_idx + IW'(1);

  always_comb begin
    byte_in = HEADER_BYTE;
    word_sh = '0;
    if (load_idx == '0) begin
      byte_in = HEADER_BYTE;
    end else if (load_idx == IW'(1)) begin
      byte_in = status_q;
    end else if (load_idx <= IW'(13)) begin
      word_sh = words_q << (8 * (int'(load_idx) - 2));
      byte_in = word_sh[95:88];
    end
`ifdef METER_FRAME_CHECKSUM_EN
    else begin
      byte_in = frame_checksum(status_q, words_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q <= '0;
      words_q  <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        status_q <= {5'b0, high_Frequency, mode};
        words_q  <= {first_data, second_data, third_data};
        byte_idx <= '0;
        busy     <= 1'b1;
      end else if (byte_done) begin
        if (more) begin
          byte_idx <= byte_idx + IW'(1);
        end else begin
          byte_idx <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .byte_in  (byte_in),
    .txd      (txd),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_meter_frame_tx.sv
module tb_meter_frame_tx;

  localparam int CPB = 4;
`ifdef METER_FRAME_CHECKSUM_EN
  localparam int FLEN = 15;
`else
  localparam int FLEN = 14;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] first_data, second_data, third_data;
  logic [1:0]  mode;
  logic        high_Frequency;
  logic        txd, busy, done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_b [0:14];
  logic [7:0] rx    [0:14];
  logic [7:0] lit_a [0:14];

  always #5 clk = ~clk;

  meter_frame_tx #(
    .CLK_FREQ(400),
    .BAUD    (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .first_data    (first_data),
    .second_data   (second_data),
    .third_data    (third_data),
    .mode          (mode),
    .high_Frequency(high_Frequency),
    .txd           (txd),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame built straight from the byte-order rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [1:0] m,
                                input logic hf);
    logic [31:0] w [0:2];
    int s;
    w[0] = a; w[1] = b; w[2] = c;
    exp_b[0] = 8'hA5;
    exp_b[1] = {5'b0, hf, m};
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++)
        exp_b[2 + 4*i + k] = 8'((w[i] >> (24 - 8*k)) & 32'hFF);
    s = 0;
    for (int i = 1; i <= 13; i++) s += int'(exp_b[i]);
    exp_b[14] = 8'(s % 256);
  endfunction

  // Expected line level j cycles after the capture edge.
  function automatic logic model_txd(input int j);
    int n, by, pos;
    n   = j / CPB;
    by  = n / 10;
    pos = n % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return exp_b[by][pos-1];
  endfunction

  task automatic frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [1:0] m, input logic hf,
                       input int poke_at, input int abort_at, input bit hold);
    int L;
    int n;
    L = FLEN * 10 * CPB;
    model(a, b, c, m, hf);
    for (int i = 0; i < 15; i++) rx[i] = '0;
    @(negedge clk);
    reset = 1'b1;
    first_data = a; second_data = b; third_data = c;
    mode = m; high_Frequency = hf;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    first_data  = $urandom;
    second_data = $urandom;
    third_data  = $urandom;
    mode        = 2'($urandom);
    high_Frequency = 1'($urandom);
    for (int j = 0; j < L; j++) begin
      if (j == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_txd", 32'(txd), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) begin
          @(posedge clk); #1;
          chk("abort_no_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        return;
      end
      chk("txd", 32'(txd), 32'(model_txd(j)));
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      n = (j / CPB) % 10;
      if ((j % CPB) == 2 && n >= 1 && n <= 8) rx[j / (CPB*10)][n-1] = txd;
      if (j == poke_at) begin
        start = 1'b1;
        first_data = 32'hFFFFFFFF;
      end
      if (j == poke_at + 3 && !hold) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_drop", 32'(busy), 32'd0);
    chk("txd_idle", 32'(txd), 32'd1);
    if (!hold) begin
      @(posedge clk); #1;
      chk("done_single", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    lit_a = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
              8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h09};

    reset = 1'b0; start = 1'b0;
    first_data = '0; second_data = '0; third_data = '0;
    mode = '0; high_Frequency = 1'b0;
    repeat (2) @(posedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    start = 1'b0;

    // Basic frame 1,2,3 with both channels present
    frame(32'd1, 32'd2, 32'd3, 2'b11, 1'b0, -1, -1, 1'b0);
    for (int i = 0; i < FLEN; i++) chk("rx_basic", 32'(rx[i]), 32'(lit_a[i]));

    // Status byte packing and MSB-first word order
    frame(32'h12345678, $urandom, $urandom, 2'b10, 1'b1, -1, -1, 1'b0);
    chk("rx_status", 32'(rx[1]), 32'h06);
    chk("rx_w0b0", 32'(rx[2]), 32'h12);
    chk("rx_w0b1", 32'(rx[3]), 32'h34);
    chk("rx_w0b2", 32'(rx[4]), 32'h56);
    chk("rx_w0b3", 32'(rx[5]), 32'h78);

    // Start while busy is ignored
    frame($urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), 100, -1, 1'b0);

    // Start held high: next frame captured on the done cycle
    frame($urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), -1, -1, 1'b1);
    frame($urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), -1, -1, 1'b0);

    // Reset mid-frame, then a clean frame right after release
    frame($urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), -1, 200, 1'b0);
    frame($urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), -1, -1, 1'b0);

    for (int r = 0; r < 3; r++)
      frame($urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/meter_frame_tx.md
METER_FRAME_TX -- requirements
Module: meter_frame_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), which SHALL be >= 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to send one frame; sampled each clk.
REQ-006 first_data  input  32  first measurement word.
REQ-007 second_data  input  32  second measurement word.
REQ-008 third_data  input  32  third measurement word.
REQ-009 mode  input  2  channel-presence mode (bit1 = sig1 present, bit0 = sig2 present).
REQ-010 high_Frequency  input  1  high-frequency range flag.
REQ-011 txd  output  1  UART serial line; idle high.
REQ-012 busy  output  1  high while a frame is in flight.
REQ-013 done  output  1  one-cycle pulse when the final stop bit completes.

Function
REQ-014 Frame byte order SHALL be: header 0xA5; status byte {5'b0, high_Frequency, mode}; first_data, second_data and third_data, each MSB byte first; then the checksum byte when CHECKSUM_EN is defined.
REQ-015 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with each bit held for exactly CLKS_PER_BIT cycles.
REQ-016 Bytes SHALL be sent back-to-back, with no idle bit between the stop bit and the next start bit.
REQ-017 When start=1 and busy=0 at edge k, all data inputs SHALL be latched at edge k, and both busy and txd=0 SHALL take effect after edge k.
REQ-018 When start=1 and busy=1, start SHALL be ignored and the latched data SHALL remain unchanged.
REQ-019 Input changes after the capture edge SHALL NOT affect the frame in flight.
REQ-020 State machine states:
  - IDLE: go to START on an accepted start.
  - START: go to DATA after CLKS_PER_BIT cycles.
  - DATA: go to STOP after 8 bits.
  - STOP: go to START if bytes remain, otherwise go to IDLE.
REQ-021 On the STOP->IDLE transition, done SHALL pulse high for one cycle and busy SHALL drop in that same cycle.
REQ-022 A start asserted while done=1 SHALL be accepted, because busy=0 in that cycle.
REQ-023 Total frame duration SHALL be FRAME_LEN*10*CLKS_PER_BIT cycles from the capture edge to the done pulse.
REQ-024 The bit counter (0..7), byte index (0..FRAME_LEN-1) and baud counter (0..CLKS_PER_BIT-1) SHALL each wrap to 0 at its terminal count.

Reset
REQ-025 While reset=0, outputs SHALL be txd=1, busy=0, done=0; the state SHALL be IDLE and all counters and latched data SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously), drive txd=1, and produce no done pulse.
REQ-027 The first start after reset deassertion SHALL be accepted at the first rising edge at which it is seen.

Configuration
REQ-028 With macro METER_FRAME_CHECKSUM_EN defined, FRAME_LEN SHALL be 15, and the last byte SHALL be the 8-bit modulo-256 sum of the status byte and the 12 data bytes (header excluded).
REQ-029 With METER_FRAME_CHECKSUM_EN undefined, FRAME_LEN SHALL be 14 and no checksum logic SHALL be present.

Structure
REQ-030 Package meter_tx_pkg SHALL hold the state enum (IDLE, START, DATA, STOP), HEADER_BYTE = 8'hA5, and the FRAME_LEN constants for both configurations.
REQ-031 Sub-module uart_byte_tx SHALL handle start/data/stop bit timing for one byte, with ports load, byte_in, txd, byte_done.
REQ-032 The top level SHALL handle capture, byte sequencing, checksum, busy and done.

Verification (CLK_FREQ=400, BAUD=100, so CLKS_PER_BIT=4)
REQ-033 Basic frame, checksum enabled: mode=2'b11, high_Frequency=0, data words 1, 2, 3, pulse start -> serial bytes A5 03 00 00 00 01 00 00 00 02 00 00 00 03 09; done fires 600 cycles after the capture edge.
REQ-034 Basic frame, checksum disabled: same stimulus as REQ-033 -> 14 bytes with no trailing 09; done fires 560 cycles after the capture edge.
REQ-035 Busy ignore: second start 100 cycles into a frame with first_data=32'hFFFFFFFF -> frame unchanged and only one done pulse.
REQ-036 Back-to-back: start held high continuously -> the next frame's start bit begins on the cycle after done, with no idle gap.
REQ-037 Reset mid-frame: reset=0 at cycle 200 -> txd=1 and busy=0 within the same cycle, and no done pulse; a new start after release -> complete, correct frame.
REQ-038 Status byte: mode=2'b10, high_Frequency=1 -> status byte 0x06; first_data=32'h12345678 -> bytes 12 34 56 78, each serialized LSB first.
